mux_sel_scheduler: RTL and testbench

//  Round-robin scheduler that owns the select of the 8:1 bit mux. Up to
//  N_CH requesters raise req; the block grants one channel at a time,

---
 rtl/mux_sel_scheduler_if.sv | 28 ++
 rtl/mux_sel_scheduler.sv | 114 +++++++++++
 tb/tb_mux_sel_scheduler.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_sel_scheduler_if.sv
// Request/grant/sample bundle between requesters, the mux datapath
// and the round-robin select scheduler.
interface mux_sel_scheduler_if #(
  parameter int N_CH  = 8,
  parameter int SEL_W = 3
);
  logic             enable;
  logic [N_CH-1:0]  req;
  logic             mux_out;
  logic [SEL_W-1:0] sel;
  logic [N_CH-1:0]  grant;
  logic             busy;
  logic             sample_valid;
  logic [SEL_W-1:0] sample_ch;
  logic             sample_bit;

  modport master (
    output enable, req, mux_out,
    input  sel, grant, busy,
    input  sample_valid, sample_ch, sample_bit
  );

  modport slave (
    input  enable, req, mux_out,
    output sel, grant, busy,
    output sample_valid, sample_ch, sample_bit
  );
endinterface

// File: rtl/mux_sel_scheduler.sv
// Round-robin owner of the 8:1 mux select: grants one channel for a
// fixed dwell, samples mux_out after a settle delay, tags it by channel.
module mux_sel_scheduler #(
  parameter int N_CH        = 8,
  parameter int SEL_W       = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int SAMPLE_DLY  = 1
) (
  input  logic clock,
  input  logic reset_n,
  mux_sel_scheduler_if.slave bus
);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] SMP_LAST = CNT_W'(SAMPLE_DLY - 1);
  localparam logic [CNT_W-1:0] HLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [N_CH-1:0]  ONE      = {{(N_CH-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(N_CH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] pick;
  logic [SEL_W-1:0] idx;
  logic             found;
  logic             start;
  logic             cap;
  logic             done;

  // Search last+1 .. last+N_CH; SEL_W arithmetic wraps mod N_CH.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = last + SEL_W'(i);
      if (!found && bus.req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    cap     = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.enable && found) begin
          start   = 1'b1;
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == SMP_LAST) begin
          cap     = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (cnt == HLD_LAST) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.sel          <= '0;
      bus.grant        <= '0;
      bus.busy         <= 1'b0;
      bus.sample_valid <= 1'b0;
      bus.sample_ch    <= '0;
      bus.sample_bit   <= 1'b0;
      last             <= LAST_RST;
      cnt              <= '0;
    end else begin
      bus.sample_valid <= cap;
      if (start) begin
        bus.sel   <= pick;
        bus.grant <= ONE << pick;
        bus.busy  <= 1'b1;
        last      <= pick;
        cnt       <= '0;
      end else if (state != IDLE) begin
        cnt <= cnt + 1'b1;
      end
      if (cap) begin
        bus.sample_bit <= bus.mux_out;
        bus.sample_ch  <= bus.sel;
      end
      if (done) begin
        bus.grant <= '0;
        bus.busy  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mux_sel_scheduler.sv
// Bench for mux_sel_scheduler: grant-age model checked every cycle,
// plus directed literal expectations for the listed scenarios.
module tb_mux_sel_scheduler;
  localparam int N_CH = 8;
  localparam int SEL_W = 3;
  localparam int HOLD = 4;
  localparam int SDLY = 1;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   check_en = 1'b0;

  mux_sel_scheduler_if #(.N_CH(N_CH), .SEL_W(SEL_W)) bus ();

  mux_sel_scheduler #(
    .N_CH(N_CH), .SEL_W(SEL_W),
    .HOLD_CYCLES(HOLD), .SAMPLE_DLY(SDLY)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  always #5 clock = ~clock;

  // Model: a grant is "age" cycles old (0 = idle); rr pointer is m_last.
  int   m_age = 0;
  int   m_ch = 0;
  int   m_last = N_CH - 1;
  bit   m_sv = 0;
  int   m_sch = 0;
  bit   m_sbit = 0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_age = 0; m_ch = 0; m_last = N_CH - 1;
      m_sv = 0; m_sch = 0; m_sbit = 0;
    end else begin
      m_sv = (m_age == SDLY);
      if (m_sv) begin
        m_sch = m_ch;
        m_sbit = bus.mux_out;
      end
      if (m_age != 0) begin
        m_age = (m_age == HOLD) ? 0 : m_age + 1;
      end else if (bus.enable && bus.req != '0) begin
        for (int k = 1; k <= N_CH; k++) begin
          if (m_age == 0 && bus.req[(m_last + k) % N_CH]) begin
            m_ch = (m_last + k) % N_CH;
            m_age = 1;
          end
        end
        m_last = m_ch;
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      chk("m_grant", int'(bus.grant),
          (m_age != 0) ? (1 << m_ch) : 0);
      chk("m_sel", int'(bus.sel), m_ch);
      chk("m_busy", int'(bus.busy), int'(m_age != 0));
      chk("m_sv", int'(bus.sample_valid), int'(m_sv));
      chk("m_sch", int'(bus.sample_ch), m_sch);
      chk("m_sbit", int'(bus.sample_bit), int'(m_sbit));
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  int q[$];

  initial begin
    bus.enable = 1'b1;
    bus.req = 8'hFF;
    bus.mux_out = 1'b0;
    // 1: reset with all requests pending
    tick(1);
    check_en = 1'b1;
    tick(1);
    chk("rst_grant", int'(bus.grant), 0);
    chk("rst_sel", int'(bus.sel), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_sv", int'(bus.sample_valid), 0);
    reset_n = 1'b1;
    tick(1);
    chk("rel_grant", int'(bus.grant), 8'h01);
    bus.req = 8'h00;
    tick(5);
    chk("t1_idle", int'(bus.grant), 0);

    // 2: single request on ch5
    bus.req = 8'h20;
    bus.mux_out = 1'b1;
    tick(1);
    bus.req = 8'h00;
    chk("t2_grant1", int'(bus.grant), 8'h20);
    chk("t2_sel", int'(bus.sel), 5);
    chk("t2_sv1", int'(bus.sample_valid), 0);
    tick(1);
    chk("t2_sv2", int'(bus.sample_valid), 1);
    chk("t2_sch", int'(bus.sample_ch), 5);
    chk("t2_sbit", int'(bus.sample_bit), 1);
    tick(1);
    chk("t2_sv3", int'(bus.sample_valid), 0);
    tick(1);
    chk("t2_grant4", int'(bus.grant), 8'h20);
    tick(1);
    chk("t2_grant5", int'(bus.grant), 0);
    chk("t2_busy5", int'(bus.busy), 0);

    // 3: full round robin from a fresh pointer
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(1);
    bus.req = 8'hFF;
    for (int t = 1; t <= 43; t++) begin
      tick(1);
      bus.mux_out = t[1];
      if ((t - 1) % 5 == 0)
        chk("rr_grant", int'(bus.grant), 1 << (((t - 1) / 5) % 8));
      if (bus.sample_valid) q.push_back(int'(bus.sample_ch));
    end
    bus.req = 8'h00;
    tick(2);
    chk("rr_nsamp", q.size(), 9);
    for (int i = 0; i < q.size(); i++) chk("rr_order", q[i], i % 8);

    // 4: wrap from ch7 to ch0
    bus.req = 8'h80;
    tick(1);
    chk("w_g7", int'(bus.grant), 8'h80);
    bus.req = 8'h81;
    tick(5);
    chk("w_g0", int'(bus.grant), 8'h01);
    tick(5);
    chk("w_g7b", int'(bus.grant), 8'h80);
    bus.req = 8'h00;
    tick(5);

    // 5: enable drop mid-grant of ch3
    bus.req = 8'h08;
    tick(1);
    chk("e_g3", int'(bus.grant), 8'h08);
    bus.req = 8'hFF;
    tick(1);
    bus.enable = 1'b0;
    chk("e_sv", int'(bus.sample_valid), 1);
    chk("e_sch", int'(bus.sample_ch), 3);
    tick(2);
    chk("e_g3c4", int'(bus.grant), 8'h08);
    tick(1);
    chk("e_idle", int'(bus.grant), 0);
    chk("e_busy", int'(bus.busy), 0);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("e_block", int'(bus.grant), 0);
    end
    bus.enable = 1'b1;
    tick(1);
    chk("e_g4", int'(bus.grant), 8'h10);

    // 6: reset in grant cycle 1 of ch4
    reset_n = 1'b0;
    #1;
    chk("r_grant", int'(bus.grant), 0);
    chk("r_sel", int'(bus.sel), 0);
    chk("r_busy", int'(bus.busy), 0);
    chk("r_sv", int'(bus.sample_valid), 0);
    tick(1);
    chk("r_sv2", int'(bus.sample_valid), 0);
    reset_n = 1'b1;
    tick(1);
    chk("r_g0", int'(bus.grant), 8'h01);
    chk("r_sv3", int'(bus.sample_valid), 0);
    tick(8);
    bus.req = 8'h00;
    tick(6);
    chk("end_idle", int'(bus.busy), 0);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
